// File: rtl/vertical_data_setup_pkg.sv
// Package for the vertical PE buffer write-side producer.
// Holds the array geometry (COLS columns of DW-bit bytes), the controller
// state encoding and the row type shared by the interfaces, the top and
// the per-column skew delay lines.
package vsetup_pkg;

  localparam int COLS  = 16;
  localparam int DW    = 8;
  // Flush counter must hold the value COLS.
  localparam int CNT_W = $clog2(COLS + 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH
  } state_t;

  typedef logic [DW-1:0] row_t [COLS];

endpackage

// File: rtl/vertical_data_setup_if.sv
// Interfaces for vertical_data_setup.
//   vertical_data_setup_row_if : row handshake from the tile fetch stage
//     in_valid, in_last, in_row (fetch -> setup), in_ready (setup -> fetch)
//     master = fetch stage, slave = vertical_data_setup
//   vertical_data_setup_col_if : per-column write port of the column FIFOs
//     fifo_WVALID_col, out_col (setup -> FIFOs), fifo_WREADY_col (FIFOs -> setup)
//     master = vertical_data_setup, slave = column FIFO bank
interface vertical_data_setup_row_if;
  import vsetup_pkg::*;

  logic in_valid;
  logic in_last;
  row_t in_row;
  logic in_ready;

  modport master (output in_valid, output in_last, output in_row, input in_ready);
  modport slave  (input in_valid, input in_last, input in_row, output in_ready);
endinterface

interface vertical_data_setup_col_if;
  import vsetup_pkg::*;

  logic [COLS-1:0] fifo_WVALID_col;
  logic [COLS-1:0] fifo_WREADY_col;
  row_t            out_col;

  modport master (output fifo_WVALID_col, output out_col, input fifo_WREADY_col);
  modport slave  (input fifo_WVALID_col, input out_col, output fifo_WREADY_col);
endinterface

// File: rtl/vertical_data_setup_skew_col_delay.sv
// skew_col_delay: DEPTH-stage delay line for one PE column.
// Every stage carries a data byte and a valid bit; the whole line shifts
// only when adv is high. The final stage is offered to the column FIFO,
// and the consumed flag remembers that it was already written while the
// rest of the array is stalled, so each entry is written exactly once.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   adv             shift enable shared by all columns
//   in_vld, in_data stage-0 input
//   wready          column FIFO can accept
//   wvalid          write valid to the column FIFO
//   out_data        final-stage data
//   v_last          final stage holds a valid entry
//   ok              this column does not block the next advance
module skew_col_delay
  import vsetup_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          adv,
  input  logic          in_vld,
  input  logic [DW-1:0] in_data,
  input  logic          wready,
  output logic          wvalid,
  output logic [DW-1:0] out_data,
  output logic          v_last,
  output logic          ok
);

  logic [DW-1:0]    data_q [DEPTH];
  logic [DW-1:0]    data_d [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic             consumed_q;
  logic             consumed_d;

  assign v_last   = vld_q[DEPTH-1];
  assign out_data = data_q[DEPTH-1];
  // Registered only: no combinational path from wready to wvalid.
  assign wvalid   = v_last && !consumed_q;
  assign ok       = !v_last || consumed_q || wready;

  always_comb begin
    data_d     = data_q;
    vld_d      = vld_q;
    consumed_d = consumed_q;
    if (adv) begin
      data_d[0] = in_data;
      vld_d[0]  = in_vld;
      for (int i = 1; i < DEPTH; i++) begin
        data_d[i] = data_q[i-1];
        vld_d[i]  = vld_q[i-1];
      end
      consumed_d = 1'b0;
    end else if (wvalid && wready) begin
      consumed_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
      vld_q      <= '0;
      consumed_q <= 1'b0;
    end else begin
      data_q     <= data_d;
      vld_q      <= vld_d;
      consumed_q <= consumed_d;
    end
  end

endmodule

// File: rtl/vertical_data_setup.sv
// vertical_data_setup: write-side producer for the 16-column vertical PE
// buffer. Takes one row per handshake, skews it diagonally (column c gets
// c+1 stages) and writes each byte into its column FIFO. After the last row
// of a tile the skew pipeline is flushed with bubbles and tile_done pulses.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   row_in     row handshake (in_valid, in_last, in_row, in_ready)
//   col_out    column FIFO writes (fifo_WVALID_col, fifo_WREADY_col, out_col)
//   busy       controller not IDLE
//   tile_done  one-cycle pulse when the flush completes
//   rows_accepted [15:0]  only when ROW_CNT_EN is defined: saturating count
//              of rows accepted in the current tile
// Build option: define ROW_CNT_EN to add the rows_accepted counter/port.
module vertical_data_setup
  import vsetup_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  vertical_data_setup_row_if.slave  row_in,
  vertical_data_setup_col_if.master col_out,
  output logic                      busy,
  output logic                      tile_done
`ifdef ROW_CNT_EN
  ,
  output logic [15:0]               rows_accepted
`endif
);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic [COLS-1:0] ok;
  logic [COLS-1:0] v_last;
  logic [COLS-1:0] wvalid_w;
  logic [COLS-1:0] wready_w;
  row_t            out_w;
  logic            adv;
  logic            in_ready_w;
  logic            accept;

  // Advance needs every column clear; an empty IDLE pipeline only moves
  // when a row is offered. rst gates the handshake so in_ready is low
  // throughout reset.
  assign adv        = (&ok) && !rst && !(state_q == IDLE && !row_in.in_valid);
  assign in_ready_w = adv && (state_q != FLUSH);
  assign accept     = row_in.in_valid && in_ready_w;
  assign busy       = (state_q != IDLE);

  assign row_in.in_ready         = in_ready_w;
  assign wready_w                = col_out.fifo_WREADY_col;
  assign col_out.fifo_WVALID_col = wvalid_w;
  assign col_out.out_col         = out_w;

  // Stage-0 valid is the accept itself, which is already low in FLUSH,
  // so flush advances push bubbles.
  for (genvar gi = 0; gi < COLS; gi++) begin : g_col
    skew_col_delay #(
      .DEPTH(gi + 1)
    ) u_col (
      .clk      (clk),
      .rst      (rst),
      .adv      (adv),
      .in_vld   (accept),
      .in_data  (row_in.in_row[gi]),
      .wready   (wready_w[gi]),
      .wvalid   (wvalid_w[gi]),
      .out_data (out_w[gi]),
      .v_last   (v_last[gi]),
      .ok       (ok[gi])
    );
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tile_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (row_in.in_last) begin
            state_d = FLUSH;
            cnt_d   = CNT_W'(COLS);
          end else begin
            state_d = STREAM;
          end
        end
      end
      STREAM: begin
        if (accept && row_in.in_last) begin
          state_d = FLUSH;
          cnt_d   = CNT_W'(COLS);
        end
      end
      FLUSH: begin
        if (cnt_q == '0) begin
          if (v_last == '0) begin
            tile_done = 1'b1;
            state_d   = IDLE;
          end
        end else if (adv) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef ROW_CNT_EN
  logic [15:0] row_cnt_q;
  logic [15:0] row_cnt_d;

  always_comb begin
    row_cnt_d = row_cnt_q;
    if (tile_done) begin
      row_cnt_d = '0;
    end else if (accept && row_cnt_q != 16'hFFFF) begin
      row_cnt_d = row_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_cnt_q <= '0;
    end else begin
      row_cnt_q <= row_cnt_d;
    end
  end

  assign rows_accepted = row_cnt_q;
`endif

endmodule
